mmap_pair_mac: RTL and testbench
================================

# mmap_pair_mac

Downstream consumer of the memory-mapped write port driven by the mmap stage (`o_we`, `o_addr`, `o_data`). It decodes writes into a control register and a data port, and unpacks each 32-bit data word into two signed 16-bit operands. It multiply-accumulates a programmed number of operand pairs and presents the sum with a done flag. It is the first compute stage of the conv2d datapath: a dot-product engine fed one pair per write.

## Interface
- `DW`, 16, operand width; data word is {L[31:16], R[15:0]}
- `ACC_W`, 40, accumulator / result width
- `CNT_W`, 8, pair-count width (max 255 pairs per job)

- `i_clk`  in  1  clock
- `i_rst`  in  1  reset. One clock; reset is synchronous and active-low.
- `i_we`  in  1  write strobe; one write per cycle max
- `i_addr`  in  1  0 = CTRL, 1 = DATA
- `i_data`  in  32  write data
- `o_busy`  out  1  high in ACCUM or DRAIN
- `o_done`  out  1  high in DONE; holds until next accepted CTRL write
- `o_result`  out  ACC_W  accumulator value (signed)
- `o_count`  out  CNT_W  pairs still expected in the current job
- `o_err`  out  1  sticky protocol-error flag

## Operation
- States: IDLE, ACCUM, DRAIN, DONE.
- CTRL write format: `i_data[CNT_W-1:0]` = N (pair count), `i_data[31]` = ABORT; other bits ignored.
- IDLE/DONE + CTRL write: clear acc, clear `o_err`, load `o_count` = N. N≠0 → ACCUM. N=0 → DONE, result 0.
- ACCUM + CTRL write with ABORT=1: → IDLE; clear acc, count, and the product pipeline.
- ACCUM + CTRL write with ABORT=0: ignored; set `o_err`.
- ACCUM + DATA write: register signed L×R (2·DW bits). Next cycle, add it sign-extended to ACC_W into acc. Decrement `o_count`. On the write that takes `o_count` 1→0, go → DRAIN.
- DRAIN: one cycle, lets the final product reach acc; → DONE.
- DATA write in IDLE, DRAIN or DONE: dropped; set `o_err`.
- `i_we`=0: no register change except pipeline advance.
- Arithmetic: two's complement; acc wraps modulo 2^ACC_W with no saturation. Worst case at defaults is 255·2^30 < 2^39, so wrap cannot occur.
- `o_err` clears only on reset or an accepted CTRL write in IDLE/DONE.

## Timing
- Reset (synchronous, `i_rst`=0 at an edge): state IDLE. `o_busy`, `o_done`, `o_result`, `o_count` and `o_err` are all 0. Product register is 0. Reset mid-job discards everything.
- DATA write sampled at edge t: product registered at t, acc updated at edge t+1.
- Last DATA at edge t: DRAIN after t, DONE after t+1. `o_done`=1 and `o_result` final from edge t+1.
- Full throughput: one DATA write per cycle with no gaps required; arbitrary gaps allowed.
- CTRL start at edge t: `o_busy`=1 and `o_count`=N after t. A DATA write at t+1 is accepted.
- Only one event per cycle is possible (single address bus), so there are no simultaneous CTRL/DATA cases.

## Structure
- Shared package `mmap_pkg` holds:
  - state enum
  - ADDR_CTRL=0, ADDR_DATA=1
  - CTRL field positions (COUNT_LSB=0, ABORT_BIT=31)
  - data-word split positions (L = [31:16], R = [15:0])
- One sub-module: `pair_mul`, a registered signed DW×DW multiplier with synchronous clear. FSM, counter and accumulator stay in the top.

## Test plan
- Reset → every output 0. CTRL N=3 then DATA 0x0002_0003, 0xFFFF_0004, 0x0005_0005 back-to-back → `o_done` two edges after the last write, `o_result`=6−4+25=27.
- CTRL N=0 → DONE next edge, `o_result`=0, `o_err`=0.
- CTRL N=255, 255 writes of 0x8000_8000 → `o_result`=255·2^30=0x3F_C000_0000, no wrap.
- DATA write in IDLE → `o_err`=1, acc unchanged. CTRL N=2 → `o_err`=0. Then a CTRL write without ABORT mid-job → `o_err`=1, job continues and completes correctly.
- CTRL N=4, two pairs, CTRL with bit31=1 → IDLE, `o_result`=0, `o_count`=0. Separately, `i_rst`=0 mid-job → all outputs 0 after the edge.

Source files
------------

// File: rtl/mmap_pkg.sv
// Shared definitions for the memory-mapped pair MAC: FSM states, register
// addresses and the bit layout of CTRL and DATA write words.
package mmap_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic ADDR_CTRL = 1'b0;
   localparam logic ADDR_DATA = 1'b1;

   localparam int COUNT_LSB = 0;
   localparam int ABORT_BIT = 31;

   localparam int L_LSB = 16;
   localparam int R_LSB = 0;

endpackage

// File: rtl/pair_mul.sv
// Registered signed DW x DW multiplier. o_valid marks a product that was
// captured on the previous edge and has not yet been consumed.
module pair_mul #(
   parameter int DW = 16
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_clr,
   input  logic                   i_en,
   input  logic signed [DW-1:0]   i_l,
   input  logic signed [DW-1:0]   i_r,
   output logic signed [2*DW-1:0] o_prod,
   output logic                   o_valid
);

   logic signed [2*DW-1:0] prod_q;
   logic signed [2*DW-1:0] prod_d;
   logic                   valid_q;

   assign prod_d = i_l * i_r;

   always_ff @(posedge i_clk) begin
      if (!i_rst || i_clr) begin
         prod_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= i_en;
         if (i_en) begin
            prod_q <= prod_d;
         end
      end
   end

   assign o_prod  = prod_q;
   assign o_valid = valid_q;

endmodule

// File: rtl/mmap_pair_mac.sv
// Dot-product engine on a memory-mapped write port: CTRL programs a pair
// count, each DATA word supplies one signed L/R pair to multiply-accumulate.
module mmap_pair_mac
   import mmap_pkg::*;
#(
   parameter int DW    = 16,
   parameter int ACC_W = 40,
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_we,
   input  logic             i_addr,
   input  logic [31:0]      i_data,
   output logic             o_busy,
   output logic             o_done,
   output logic [ACC_W-1:0] o_result,
   output logic [CNT_W-1:0] o_count,
   output logic             o_err
);

   state_e             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               err_q, err_d;

   logic               ctrlWr, dataWr;
   logic               startOk, abortOk, dataOk, lastPair;
   logic [CNT_W-1:0]   ctrlCount;
   logic signed [DW-1:0]   opL, opR;
   logic signed [2*DW-1:0] prod;
   logic               prodValid;
   logic [ACC_W-1:0]   prodExt;

   assign ctrlWr    = i_we && (i_addr == ADDR_CTRL);
   assign dataWr    = i_we && (i_addr == ADDR_DATA);
   assign ctrlCount = i_data[COUNT_LSB +: CNT_W];
   assign opL       = i_data[L_LSB +: DW];
   assign opR       = i_data[R_LSB +: DW];

   assign startOk  = ctrlWr && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign abortOk  = ctrlWr && (state_q == ST_ACCUM) && i_data[ABORT_BIT];
   assign dataOk   = dataWr && (state_q == ST_ACCUM);
   assign lastPair = dataOk && (count_q == CNT_W'(1));

   pair_mul #(.DW(DW)) uMul (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clr   (abortOk),
      .i_en    (dataOk),
      .i_l     (opL),
      .i_r     (opR),
      .o_prod  (prod),
      .o_valid (prodValid)
   );

   assign prodExt = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (startOk) begin
               state_d = (ctrlCount != '0) ? ST_ACCUM : ST_DONE;
            end
         end
         ST_ACCUM: begin
            if (abortOk) begin
               state_d = ST_IDLE;
            end else if (lastPair) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: state_d = ST_DONE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // The product captured last edge is folded in unless a start/abort wipes the job.
   always_comb begin
      acc_d   = prodValid ? (acc_q + prodExt) : acc_q;
      count_d = count_q;
      err_d   = err_q;
      if (startOk) begin
         acc_d   = '0;
         count_d = ctrlCount;
         err_d   = 1'b0;
      end else if (abortOk) begin
         acc_d   = '0;
         count_d = '0;
      end else if (dataOk) begin
         count_d = count_q - CNT_W'(1);
      end
      if (ctrlWr && (state_q == ST_ACCUM) && !i_data[ABORT_BIT]) begin
         err_d = 1'b1;
      end
      if (dataWr && (state_q != ST_ACCUM)) begin
         err_d = 1'b1;
      end
   end

   always_comb begin
      o_busy = 1'b0;
      o_done = 1'b0;
      unique case (state_q)
         ST_ACCUM, ST_DRAIN: o_busy = 1'b1;
         ST_DONE:            o_done = 1'b1;
         default:            ;
      endcase
   end

   assign o_result = acc_q;
   assign o_count  = count_q;
   assign o_err    = err_q;

endmodule

// File: tb/tb_mmap_pair_mac.sv
// Bench for mmap_pair_mac: directed vector table, hand sequences for the
// long job and mid-job reset, then random traffic against a job-level model.
module tb_mmap_pair_mac;

   logic        i_clk;
   logic        i_rst;
   logic        i_we;
   logic        i_addr;
   logic [31:0] i_data;
   logic        o_busy;
   logic        o_done;
   logic [39:0] o_result;
   logic [7:0]  o_count;
   logic        o_err;

   int checks;
   int errors;

   mmap_pair_mac dut (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_we     (i_we),
      .i_addr   (i_addr),
      .i_data   (i_data),
      .o_busy   (o_busy),
      .o_done   (o_done),
      .o_result (o_result),
      .o_count  (o_count),
      .o_err    (o_err)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Job-level reference: visible sum, one product in flight, pairs left.
   int     mPhase;
   int     mRemain;
   longint mSum;
   longint mPend;
   bit     mPendValid;
   bit     mErr;

   task automatic modelStep(input bit rstn, input bit we, input bit addr, input logic [31:0] data);
      int     oldPhase;
      logic [15:0] l, r;
      if (!rstn) begin
         mPhase = 0; mRemain = 0; mSum = 0; mPend = 0; mPendValid = 0; mErr = 0;
         return;
      end
      oldPhase = mPhase;
      if (mPendValid) mSum = mSum + mPend;
      mPendValid = 0;
      if (oldPhase == 2) mPhase = 3;
      if (we && addr == 1'b0) begin
         if (oldPhase == 0 || oldPhase == 3) begin
            mSum = 0; mErr = 0;
            mRemain = int'(data[7:0]);
            mPhase = (mRemain != 0) ? 1 : 3;
         end else if (oldPhase == 1) begin
            if (data[31]) begin
               mPhase = 0; mSum = 0; mRemain = 0;
            end else begin
               mErr = 1;
            end
         end
      end
      if (we && addr == 1'b1) begin
         if (oldPhase == 1) begin
            l = data[31:16];
            r = data[15:0];
            mPend = longint'($signed(l)) * longint'($signed(r));
            mPendValid = 1;
            mRemain = mRemain - 1;
            if (mRemain == 0) mPhase = 2;
         end else begin
            mErr = 1;
         end
      end
   endtask

   task automatic applyStimulus(input bit rstn, input bit we, input bit addr, input logic [31:0] data);
      i_rst  = rstn;
      i_we   = we;
      i_addr = addr;
      i_data = data;
      @(posedge i_clk);
      modelStep(rstn, we, addr, data);
      #1;
      i_rst = 1'b1;
      i_we  = 1'b0;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkModel(input string tag);
      logic [63:0] sumBits;
      sumBits = mSum;
      checkOutput({tag, " busy"},   64'(o_busy),   64'((mPhase == 1 || mPhase == 2) ? 1 : 0));
      checkOutput({tag, " done"},   64'(o_done),   64'((mPhase == 3) ? 1 : 0));
      checkOutput({tag, " result"}, 64'(o_result), 64'(sumBits[39:0]));
      checkOutput({tag, " count"},  64'(o_count),  64'(mRemain));
      checkOutput({tag, " err"},    64'(o_err),    64'(mErr));
   endtask

   typedef struct {
      bit          we;
      bit          addr;
      logic [31:0] data;
      bit          expBusy;
      bit          expDone;
      logic [39:0] expResult;
      logic [7:0]  expCount;
      bit          expErr;
   } vec_t;

   vec_t vecs[19];

   initial begin
      int r;
      logic [31:0] d;
      checks = 0;
      errors = 0;
      i_rst = 1'b0; i_we = 1'b0; i_addr = 1'b0; i_data = '0;

      vecs[0]  = '{1, 0, 32'h0000_0003, 1, 0, 40'd0,  8'd3, 0};
      vecs[1]  = '{1, 1, 32'h0002_0003, 1, 0, 40'd0,  8'd2, 0};
      vecs[2]  = '{1, 1, 32'hFFFF_0004, 1, 0, 40'd6,  8'd1, 0};
      vecs[3]  = '{1, 1, 32'h0005_0005, 1, 0, 40'd2,  8'd0, 0};
      vecs[4]  = '{0, 0, 32'h0000_0000, 0, 1, 40'd27, 8'd0, 0};
      vecs[5]  = '{1, 0, 32'h0000_0000, 0, 1, 40'd0,  8'd0, 0};
      vecs[6]  = '{1, 1, 32'h0001_0001, 0, 1, 40'd0,  8'd0, 1};
      vecs[7]  = '{1, 0, 32'h0000_0002, 1, 0, 40'd0,  8'd2, 0};
      vecs[8]  = '{1, 0, 32'h0000_0005, 1, 0, 40'd0,  8'd2, 1};
      vecs[9]  = '{1, 1, 32'h0003_0004, 1, 0, 40'd0,  8'd1, 1};
      vecs[10] = '{1, 1, 32'hFFFE_FFFD, 1, 0, 40'd12, 8'd0, 1};
      vecs[11] = '{0, 0, 32'h0000_0000, 0, 1, 40'd18, 8'd0, 1};
      vecs[12] = '{1, 0, 32'h0000_0004, 1, 0, 40'd0,  8'd4, 0};
      vecs[13] = '{1, 1, 32'h0007_0007, 1, 0, 40'd0,  8'd3, 0};
      vecs[14] = '{1, 1, 32'h0001_0002, 1, 0, 40'd49, 8'd2, 0};
      vecs[15] = '{1, 0, 32'h8000_0000, 0, 0, 40'd0,  8'd0, 0};
      vecs[16] = '{0, 0, 32'h0000_0000, 0, 0, 40'd0,  8'd0, 0};
      vecs[17] = '{1, 1, 32'h0002_0002, 0, 0, 40'd0,  8'd0, 1};
      vecs[18] = '{0, 0, 32'h0000_0000, 0, 0, 40'd0,  8'd0, 1};

      applyStimulus(0, 0, 0, '0);
      applyStimulus(0, 0, 0, '0);
      checkOutput("reset busy",   64'(o_busy),   64'd0);
      checkOutput("reset done",   64'(o_done),   64'd0);
      checkOutput("reset result", 64'(o_result), 64'd0);
      checkOutput("reset count",  64'(o_count),  64'd0);
      checkOutput("reset err",    64'(o_err),    64'd0);

      for (int i = 0; i < 19; i++) begin
         applyStimulus(1, vecs[i].we, vecs[i].addr, vecs[i].data);
         checkOutput($sformatf("vec%0d busy", i),   64'(o_busy),   64'(vecs[i].expBusy));
         checkOutput($sformatf("vec%0d done", i),   64'(o_done),   64'(vecs[i].expDone));
         checkOutput($sformatf("vec%0d result", i), 64'(o_result), 64'(vecs[i].expResult));
         checkOutput($sformatf("vec%0d count", i),  64'(o_count),  64'(vecs[i].expCount));
         checkOutput($sformatf("vec%0d err", i),    64'(o_err),    64'(vecs[i].expErr));
      end

      // Longest job with the most negative operands: largest reachable sum.
      applyStimulus(1, 1, 0, 32'h0000_00FF);
      checkOutput("n255 count start", 64'(o_count), 64'd255);
      for (int i = 0; i < 255; i++) applyStimulus(1, 1, 1, 32'h8000_8000);
      checkOutput("n255 drain busy", 64'(o_busy), 64'd1);
      checkOutput("n255 drain count", 64'(o_count), 64'd0);
      applyStimulus(1, 0, 0, '0);
      checkOutput("n255 done", 64'(o_done), 64'd1);
      checkOutput("n255 result", 64'(o_result), 64'h3F_C000_0000);
      checkOutput("n255 err", 64'(o_err), 64'd0);

      applyStimulus(1, 1, 0, 32'h0000_0005);
      applyStimulus(1, 1, 1, 32'h0003_0003);
      applyStimulus(1, 1, 1, 32'h0004_0004);
      checkOutput("midjob result", 64'(o_result), 64'd9);
      applyStimulus(0, 0, 0, '0);
      checkOutput("midrst busy",   64'(o_busy),   64'd0);
      checkOutput("midrst done",   64'(o_done),   64'd0);
      checkOutput("midrst result", 64'(o_result), 64'd0);
      checkOutput("midrst count",  64'(o_count),  64'd0);
      checkOutput("midrst err",    64'(o_err),    64'd0);
      applyStimulus(1, 0, 0, '0);
      checkOutput("midrst pipe flushed", 64'(o_result), 64'd0);

      for (int i = 0; i < 800; i++) begin
         r = $urandom_range(0, 99);
         if (r < 2) begin
            applyStimulus(0, 0, 0, '0);
         end else if (r < 5) begin
            d = 32'h8000_0000 | ($urandom & 32'h7FFF_FFFF);
            applyStimulus(1, 1, 0, d);
         end else if (r < 12) begin
            d = ($urandom & 32'h7FFF_FF00) | 32'($urandom_range(0, 6));
            applyStimulus(1, 1, 0, d);
         end else if (r < 70) begin
            applyStimulus(1, 1, 1, $urandom);
         end else begin
            applyStimulus(1, 0, 1'($urandom), $urandom);
         end
         checkModel($sformatf("rand%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
